// File: rtl/mcore_pkg.sv
// Shared types and encodings for the multicycle core: FSM states, opcode/funct
// constants, ALU control and immediate-format selection.
package mcore_pkg;

   localparam int NUM_REGS = 32;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXEC_R,
      EXEC_I,
      ALUWB,
      BEQ,
      JAL,
      TRAP
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J
   } imm_src_e;

   // funct7[5] selects subtract only for register-register ops; addi has no subi.
   function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3,
                                            input logic       funct7_b5,
                                            input logic       is_rtype);
      alu_ctrl_e ctrl;
      case (funct3)
         F3_ADD:  ctrl = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
         F3_SLT:  ctrl = ALU_SLT;
         F3_OR:   ctrl = ALU_OR;
         F3_AND:  ctrl = ALU_AND;
         default: ctrl = ALU_ADD;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/mcore_regfile.sv
// 32-entry register file: two read ports, one write port, one debug read port.
// x0 is hardwired to zero.
module mcore_regfile
   import mcore_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       raddr1,
   input  logic [4:0]       raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [4:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1   = (raddr1   == 5'd0) ? '0 : regs_q[raddr1];
   assign rdata2   = (raddr2   == 5'd0) ? '0 : regs_q[raddr2];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32-subset core sharing one memory port between fetch and data
// accesses; one FSM state per clock.
module multicycle_core
   import mcore_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   input  logic [4:0]       Debug_Source,
   output logic [WIDTH-1:0] Debug_Out,
   output logic [WIDTH-1:0] Debug_PC,
   output logic             Illegal
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] old_pc_q, old_pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             illegal_q, illegal_d;

   logic [6:0]       opcode;
   logic [4:0]       rd, rs1, rs2;
   logic [2:0]       funct3;
   logic             funct7_b5;
   imm_src_e         imm_src;
   logic [WIDTH-1:0] imm_ext;

   alu_ctrl_e               alu_ctrl;
   logic [WIDTH-1:0]        alu_b;
   logic signed [WIDTH-1:0] alu_a_s, alu_b_s;
   logic [WIDTH-1:0]        alu_y;

   logic [WIDTH-1:0] rf_rdata1, rf_rdata2, rf_wdata;
   logic             rf_we;
   logic             mem_req_c, mem_we_c;
   logic [WIDTH-1:0] mem_addr_c;

   assign opcode    = ir_q[6:0];
   assign rd        = ir_q[11:7];
   assign funct3    = ir_q[14:12];
   assign rs1       = ir_q[19:15];
   assign rs2       = ir_q[24:20];
   assign funct7_b5 = ir_q[30];

   mcore_regfile #(.WIDTH(WIDTH)) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .raddr1   (rs1),
      .raddr2   (rs2),
      .rdata1   (rf_rdata1),
      .rdata2   (rf_rdata2),
      .we       (rf_we),
      .waddr    (rd),
      .wdata    (rf_wdata),
      .dbg_addr (Debug_Source),
      .dbg_data (Debug_Out)
   );

   always_comb begin
      imm_src = IMM_I;
      case (opcode)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

   always_comb begin
      imm_ext = '0;
      case (imm_src)
         IMM_I: imm_ext = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
         IMM_S: imm_ext = {{(WIDTH-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         IMM_B: imm_ext = {{(WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7],
                           ir_q[30:25], ir_q[11:8], 1'b0};
         IMM_J: imm_ext = {{(WIDTH-21){ir_q[31]}}, ir_q[31], ir_q[19:12],
                           ir_q[20], ir_q[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   assign alu_ctrl = alu_decode(funct3, funct7_b5, state_q == EXEC_R);
   assign alu_b    = (state_q == EXEC_R) ? b_q : imm_ext;
   assign alu_a_s  = a_q;
   assign alu_b_s  = alu_b;

   always_comb begin
      alu_y = '0;
      case (alu_ctrl)
         ALU_ADD: alu_y = a_q + alu_b;
         ALU_SUB: alu_y = a_q - alu_b;
         ALU_AND: alu_y = a_q & alu_b;
         ALU_OR:  alu_y = a_q | alu_b;
         ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, (alu_a_s < alu_b_s)};
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      old_pc_d   = old_pc_q;
      ir_d       = ir_q;
      a_d        = a_q;
      b_d        = b_q;
      alu_out_d  = alu_out_q;
      data_d     = data_q;
      illegal_d  = illegal_q;
      mem_req_c  = 1'b0;
      mem_we_c   = 1'b0;
      mem_addr_c = pc_q;
      rf_we      = 1'b0;
      rf_wdata   = alu_out_q;

      case (state_q)
         FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               ir_d     = mem_rdata;
               old_pc_d = pc_q;
               pc_d     = pc_q + WIDTH'(4);
               state_d  = DECODE;
            end
         end
         DECODE: begin
            a_d       = rf_rdata1;
            b_d       = rf_rdata2;
            alu_out_d = old_pc_q + imm_ext;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXEC_R;
               OP_I:         state_d = EXEC_I;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
               default: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_out_d = a_q + imm_ext;
            state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_req_c  = 1'b1;
            mem_addr_c = alu_out_q;
            if (mem_ready) begin
               data_d  = mem_rdata;
               state_d = MEMWB;
            end
         end
         MEMWB: begin
            rf_we    = 1'b1;
            rf_wdata = data_q;
            state_d  = FETCH;
         end
         MEMWR: begin
            mem_req_c  = 1'b1;
            mem_we_c   = 1'b1;
            mem_addr_c = alu_out_q;
            if (mem_ready) begin
               state_d = FETCH;
            end
         end
         EXEC_R, EXEC_I: begin
            alu_out_d = alu_y;
            state_d   = ALUWB;
         end
         ALUWB: begin
            rf_we   = 1'b1;
            state_d = FETCH;
         end
         BEQ: begin
            if (a_q == b_q) begin
               pc_d = alu_out_q;
            end
            state_d = FETCH;
         end
         // Jump target was formed in DECODE; the link value retires through ALUWB.
         JAL: begin
            pc_d      = alu_out_q;
            alu_out_d = old_pc_q + WIDTH'(4);
            state_d   = ALUWB;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         old_pc_q  <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         data_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         old_pc_q  <= old_pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         data_q    <= data_d;
         illegal_q <= illegal_d;
      end
   end

   // Gating with reset abandons any in-flight request in the same cycle.
   assign mem_req   = mem_req_c & ~reset;
   assign mem_we    = mem_we_c & ~reset;
   assign mem_addr  = mem_addr_c;
   assign mem_wdata = b_q;
   assign Debug_PC  = pc_q;
   assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: word memory model, store scoreboard and
// cycle-exact register/PC checks.
module tb_multicycle_core;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [4:0]  Debug_Source;
   logic [31:0] Debug_Out;
   logic [31:0] Debug_PC;
   logic        Illegal;

   logic [31:0] mem [0:255];

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t wq[$];

   int n_checks = 0;
   int n_errors = 0;

   multicycle_core dut (
      .clk          (clk),
      .reset        (reset),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .Debug_Source (Debug_Source),
      .Debug_Out    (Debug_Out),
      .Debug_PC     (Debug_PC),
      .Illegal      (Illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
      Debug_Source = r;
      #1;
      chk(tag, Debug_Out, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      logic [31:0] v;
      v = imm;
      return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], rs2, rs1, 3'b000, v[4:1], v[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   // Memory write port and store scoreboard, sampled mid-cycle ahead of the commit edge.
   always @(negedge clk) begin
      #2;
      if (mem_req && mem_we && mem_ready) begin
         n_checks++;
         assert (wq.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_write: observed addr=%h data=%h expected no write",
                   mem_addr, mem_wdata);
         end
         if (wq.size() != 0) begin
            wr_t e;
            e = wq.pop_front();
            chk("store_addr", mem_addr, e.addr);
            chk("store_data", mem_wdata, e.data);
         end
         mem[mem_addr[9:2]] = mem_wdata;
      end
   end

   initial begin
      wr_t w;
      reset        = 1'b1;
      mem_ready    = 1'b1;
      Debug_Source = 5'd0;

      clear_mem();
      mem[0]  = enc_i(5, 0, 3'b000, 1, 7'h13);          // addi x1,x0,5
      mem[1]  = enc_i(7, 0, 3'b000, 2, 7'h13);          // addi x2,x0,7
      mem[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);          // add  x3,x1,x2
      mem[3]  = enc_s(8, 3, 0);                         // sw   x3,8(x0)
      mem[4]  = enc_i(8, 0, 3'b010, 4, 7'h03);          // lw   x4,8(x0)
      mem[5]  = enc_b(100, 2, 1);                       // beq  x1,x2,+100 (not taken)
      mem[6]  = enc_j(16, 0);                           // jal  x0,+16 -> 40
      mem[8]  = enc_j(16, 5);                           // 0x20: jal x5,+16 -> 0x30
      mem[10] = enc_b(-8, 1, 1);                        // 40: beq x1,x1,-8 -> 32
      mem[12] = enc_i(9, 0, 3'b000, 0, 7'h13);          // addi x0,x0,9
      mem[13] = enc_r(7'h20, 2, 1, 3'b000, 6);          // sub  x6,x1,x2
      mem[14] = enc_r(7'h00, 1, 6, 3'b010, 7);          // slt  x7,x6,x1
      mem[15] = enc_i(32'hF0, 6, 3'b111, 8, 7'h13);     // andi x8,x6,0xF0
      mem[16] = enc_i(32'h100, 1, 3'b110, 9, 7'h13);    // ori  x9,x1,0x100
      mem[17] = enc_i(1, 6, 3'b010, 10, 7'h13);         // slti x10,x6,1
      mem[18] = enc_r(7'h00, 2, 1, 3'b111, 11);         // and  x11,x1,x2
      mem[19] = enc_r(7'h00, 2, 1, 3'b110, 12);         // or   x12,x1,x2
      mem[20] = enc_i(-1, 0, 3'b000, 13, 7'h13);        // addi x13,x0,-1
      mem[21] = enc_r(7'h00, 13, 13, 3'b000, 14);       // add  x14,x13,x13
      mem[22] = 32'h0000_007F;                          // unsupported opcode

      cyc(2);
      chk("rst_pc", Debug_PC, 32'h0);
      chk("rst_illegal", {31'b0, Illegal}, 32'h0);
      chk("rst_req", {31'b0, mem_req}, 32'h0);
      chk("rst_we", {31'b0, mem_we}, 32'h0);
      reset = 1'b0;
      #1;
      chk("first_fetch_req", {31'b0, mem_req}, 32'h1);
      chk("first_fetch_addr", mem_addr, 32'h0);

      cyc(4);
      chk_reg("x1_addi", 1, 32'd5);
      chk("pc_after_addi1", Debug_PC, 32'd4);
      cyc(4);
      chk_reg("x2_addi", 2, 32'd7);
      cyc(3);
      chk_reg("x3_before_4th_cycle", 3, 32'd0);
      cyc(1);
      chk_reg("x3_add", 3, 32'd12);
      chk("pc_after_add", Debug_PC, 32'd12);

      w.addr = 32'd8;
      w.data = 32'd12;
      wq.push_back(w);
      cyc(4);
      chk("pc_after_sw", Debug_PC, 32'd16);
      cyc(4);
      chk_reg("x4_before_5th_cycle", 4, 32'd0);
      cyc(1);
      chk_reg("x4_lw", 4, 32'd12);
      chk("pc_after_lw", Debug_PC, 32'd20);

      cyc(3);
      chk("pc_beq_not_taken", Debug_PC, 32'd24);
      cyc(4);
      chk("pc_jal_x0", Debug_PC, 32'd40);
      chk_reg("x0_after_jal_x0", 0, 32'd0);
      cyc(2);
      chk("pc_beq_mid", Debug_PC, 32'd44);
      cyc(1);
      chk("pc_beq_taken", Debug_PC, 32'd32);
      cyc(4);
      chk_reg("x5_jal_link", 5, 32'h24);
      chk("pc_jal_target", Debug_PC, 32'h30);

      cyc(4);
      chk_reg("x0_addi_discard", 0, 32'd0);
      cyc(4);
      chk_reg("x6_sub", 6, 32'hFFFF_FFFE);
      cyc(4);
      chk_reg("x7_slt_signed", 7, 32'd1);
      cyc(4);
      chk_reg("x8_andi", 8, 32'h0000_00F0);
      cyc(4);
      chk_reg("x9_ori", 9, 32'h0000_0105);
      cyc(4);
      chk_reg("x10_slti_signed", 10, 32'd1);
      cyc(4);
      chk_reg("x11_and", 11, 32'd5);
      cyc(4);
      chk_reg("x12_or", 12, 32'd7);
      cyc(4);
      chk_reg("x13_addi_neg", 13, 32'hFFFF_FFFF);
      cyc(4);
      chk_reg("x14_add_wrap", 14, 32'hFFFF_FFFE);
      chk("pc_before_illegal", Debug_PC, 32'd88);

      cyc(2);
      chk("illegal_set", {31'b0, Illegal}, 32'h1);
      chk("trap_req", {31'b0, mem_req}, 32'h0);
      chk("trap_pc", Debug_PC, 32'd92);
      cyc(3);
      chk("illegal_sticky", {31'b0, Illegal}, 32'h1);
      chk("trap_req_hold", {31'b0, mem_req}, 32'h0);
      chk("trap_pc_frozen", Debug_PC, 32'd92);

      reset = 1'b1;
      cyc(1);
      chk("trap_reset_illegal", {31'b0, Illegal}, 32'h0);
      chk("trap_reset_pc", Debug_PC, 32'h0);
      chk_reg("trap_reset_x1", 1, 32'd0);

      clear_mem();
      mem[0]    = enc_i(5, 0, 3'b000, 1, 7'h13);       // addi x1,x0,5
      mem_ready = 1'b0;
      cyc(1);
      reset = 1'b0;
      #1;
      chk("wait_addr_c1", mem_addr, 32'h0);
      chk("wait_req_c1", {31'b0, mem_req}, 32'h1);
      cyc(1);
      chk("wait_addr_c2", mem_addr, 32'h0);
      chk("wait_pc_c2", Debug_PC, 32'h0);
      cyc(1);
      chk("wait_addr_c3", mem_addr, 32'h0);
      chk("wait_we_c3", {31'b0, mem_we}, 32'h0);
      cyc(1);
      mem_ready = 1'b1;
      cyc(3);
      chk_reg("wait_x1_early", 1, 32'd0);
      cyc(1);
      chk_reg("wait_x1_retired", 1, 32'd5);
      chk("wait_pc", Debug_PC, 32'd4);

      reset = 1'b1;
      clear_mem();
      mem[0] = enc_i(33, 0, 3'b000, 1, 7'h13);          // addi x1,x0,33
      mem[1] = enc_s(64, 1, 0);                         // sw   x1,64(x0)
      cyc(2);
      reset = 1'b0;
      cyc(6);
      mem_ready = 1'b0;
      cyc(1);
      chk("memwr_req", {31'b0, mem_req}, 32'h1);
      chk("memwr_we", {31'b0, mem_we}, 32'h1);
      chk("memwr_addr", mem_addr, 32'd64);
      chk("memwr_wdata", mem_wdata, 32'd33);
      cyc(2);
      chk("memwr_addr_stable", mem_addr, 32'd64);
      chk("memwr_wdata_stable", mem_wdata, 32'd33);
      chk("memwr_we_stable", {31'b0, mem_we}, 32'h1);
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("abort_req", {31'b0, mem_req}, 32'h0);
      chk("abort_we", {31'b0, mem_we}, 32'h0);
      cyc(1);
      chk("abort_req_next", {31'b0, mem_req}, 32'h0);
      chk("abort_no_write", mem[16], 32'h0);
      reset = 1'b0;
      #1;
      chk("refetch_req", {31'b0, mem_req}, 32'h1);
      chk("refetch_addr", mem_addr, 32'h0);
      chk("scoreboard_empty", wq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath, register and memory-bus width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Clock and reset SHALL be one clock, clk, with reset synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mem_req  output  1  unified instruction/data memory request.
REQ-007 mem_we  output  1  request is a write when high.
REQ-008 mem_addr  output  WIDTH  byte address, word-aligned.
REQ-009 mem_wdata  output  WIDTH  store data.
REQ-010 mem_rdata  input  WIDTH  read data, valid when mem_ready is high.
REQ-011 mem_ready  input  1  completes the current request.
REQ-012 Debug_Source  input  5  register index for Debug_Out.
REQ-013 Debug_Out  output  WIDTH  combinational read of register Debug_Source.
REQ-014 Debug_PC  output  WIDTH  current PC register.
REQ-015 Illegal  output  1  sticky flag, high after an unsupported opcode.

Function
REQ-016 The core SHALL execute lw, sw, R-type add/sub/and/or/slt, addi/andi/ori/slti, beq and jal over one shared memory port, one state per cycle.
REQ-017 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BEQ, JAL and TRAP.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; the FSM stays in FETCH until mem_ready; on mem_ready it latches IR<=mem_rdata and OldPC<=PC, sets PC<=PC+4, and goes to DECODE.
REQ-019 DECODE: latch A<=rf[rs1] and B<=rf[rs2], compute OldPC+ImmExt, then branch by opcode: lw/sw->MEMADR, R->EXEC_R, I-ALU->EXEC_I, beq->BEQ, jal->JAL, otherwise->TRAP.
REQ-020 MEMADR: ALUOut<=A+ImmExt; lw->MEMRD, sw->MEMWR.
REQ-021 MEMRD: read request at ALUOut; on mem_ready latch Data<=mem_rdata and go to MEMWB; MEMWB: rf[rd]<=Data, then FETCH.
REQ-022 MEMWR: mem_we=1, mem_addr=ALUOut, mem_wdata=B; on mem_ready go to FETCH.
REQ-023 EXEC_R/EXEC_I: ALUOut<=A op B / A op ImmExt, then ALUWB; ALUWB: rf[rd]<=ALUOut, then FETCH.
REQ-024 BEQ: if A==B then PC<=OldPC+ImmExt; then FETCH.
REQ-025 JAL: rf[rd]<=OldPC+4 and PC<=OldPC+ImmExt; then FETCH.
REQ-026 TRAP SHALL be terminal until reset, with Illegal=1 and mem_req=0.
REQ-027 With zero-wait memory (mem_ready always 1), instruction latencies SHALL be: beq 3 cycles, R/I-ALU/sw/jal 4, lw 5; each memory wait cycle adds 1.
REQ-028 While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata SHALL stay stable; mem_ready SHALL be ignored while mem_req=0.
REQ-029 Register x0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-030 slt SHALL be a signed compare; all arithmetic SHALL wrap modulo 2^WIDTH.
REQ-031 ImmExt SHALL be sign-extended to WIDTH from the I, S, B and J formats; B/J offsets SHALL have LSB 0.

Reset
REQ-032 On reset the core SHALL set PC=RESET_PC, state=FETCH, Illegal=0, all registers to 0, and IR, A, B, ALUOut and Data to 0.
REQ-033 During reset, mem_req and mem_we SHALL be 0; reset asserted mid-request SHALL abandon the request, and a pending mem_ready SHALL be ignored.
REQ-034 The first fetch SHALL be issued in the first cycle after reset deasserts.

Structure
REQ-035 Package mcore_pkg SHALL hold the state enum, the opcode/funct constants, the ALU control encoding and the ImmSrc encoding.
REQ-036 Sub-module mcore_regfile (2 read ports, 1 write port, debug read port, synchronous reset) SHALL hold the registers; the FSM, ALU and extender SHALL stay in multicycle_core.

Verification
REQ-037 Zero-wait memory with program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 -> x3=12 (Debug_Out) and Debug_PC=12, with the third instruction taking 4 cycles.
REQ-038 sw x3,8(x0) then lw x4,8(x0) -> write at address 8 with data 12, then x4=12; lw takes 5 cycles.
REQ-039 mem_ready held low for 3 cycles during FETCH -> address stays stable and the instruction retires 3 cycles later.
REQ-040 beq x1,x1,-8 -> PC=OldPC-8 after 3 cycles; jal x5,16 at PC 0x20 -> x5=0x24, PC=0x30.
REQ-041 Opcode 0x7F -> Illegal=1, mem_req stays 0, PC frozen; reset then -> Illegal=0, PC=RESET_PC.
REQ-042 addi x0,x0,9 -> Debug_Out for x0 reads 0; reset asserted during a MEMWR wait -> mem_req=0 the next cycle and no write occurs.
